fulladder: RTL and testbench
============================

// Module: fulladder
// PURPOSE
//  - 1-bit full adder: s = x^y^z, c = majority(x,y,z); s/c are purely combinational, zero latency.
//  - Arithmetic leaf cell for ripple-carry chains and the adder bring-up bench.
//  - Adds registered copies of sum/carry and a sticky input-combination coverage vector for in-system checking.
// PARAMETERS
//  - none (fixed 1-bit cell; wider adders are built by chaining instances)
// PORTS
//  - clk    in   1  system clock; rising edge; used only by the registered outputs and coverage
//  - rst_n  in   1  reset, asynchronous assert, active-low
//  - x      in   1  addend A
//  - y      in   1  addend B
//  - z      in   1  carry-in
//  - s      out  1  sum, combinational
//  - c      out  1  carry-out, combinational
//  - s_q    out  1  s registered on clk
//  - c_q    out  1  c registered on clk
//  - cov    out  8  sticky coverage; bit index {x,y,z} set once that combination has been sampled
// Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
// BEHAVIOUR
//  - s = x ^ y ^ z; c = (x&y) | (z&(x^y)).
//  - s and c do not depend on clk, rst_n or any state.
//  - s and c are correct with clk and rst_n left unconnected.
//  - s and c settle within one delta of any input change; no glitch requirement.
//  - Truth table {x,y,z} -> {c,s}: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
//  - rst_n low, at any time and asynchronously: s_q=0, c_q=0, cov=8'h00; held while low.
//  - rst_n release: registers update from the next rising clk edge.
//  - Each rising clk edge with rst_n high:
//    - s_q <= s; c_q <= c (1-cycle latency).
//    - cov[{x,y,z}] <= 1.
//  - cov bits never clear except by reset.
//  - cov == 8'hFF signals exhaustive coverage.
//  - Reset mid-operation: registered outputs and cov return to 0 immediately; s/c are unaffected.
//  - X/Z on any input propagates to s/c.
//  - No X may enter the registers after reset while the inputs are known.
// STRUCTURE
//  - Sub-module half_adder (a,b -> sum=a^b, carry=a&b), instantiated twice:
//    - ha0(x,y) -> p, g0
//    - ha1(p,z) -> s, g1
//    - c = g0 | g1
//  - Registers and cov in one always block sensitive to posedge clk / negedge rst_n.
//  - No shared package needed.
//  - If one exists, the reset level constant and RST_ACTIVE_LOW belong in the common package.
// TESTING
//  - Clock and reset unconnected: apply all 8 {x,y,z} in ascending order, 3 ns apart.
//    - s/c must follow the truth table, e.g. 011 -> c=1, s=0; 111 -> c=1, s=1.
//  - rst_n=0, then sweep all 8 inputs with clk running:
//    - s_q=c_q=0 and cov=00 throughout.
//    - s/c still correct.
//  - Release reset, apply 101, one rising edge:
//    - s_q=0, c_q=1.
//    - cov=8'h20.
//  - Apply all 8 combinations, one per clock:
//    - s_q/c_q lag s/c by exactly one edge.
//    - cov=8'hFF after the 8th edge.
//  - Assert rst_n mid-cycle (between edges) with x=y=z=1:
//    - s_q, c_q and cov drop to 0 before the next edge.
//    - s=c=1 unchanged.
//  - Random 1000 vectors: s/c match x+y+z as a 2-bit sum; s_q/c_q match the previous cycle.

Source files
------------

// File: rtl/fulladder_pkg.sv
// Common definitions for the fulladder leaf cell: reset polarity, coverage
// vector sizing, registered-result payload and the coverage mask helper.
`timescale 1ns/1ps
package fulladder_pkg;

    // Reset polarity; RST_LEVEL is the rst_n value that holds the registers cleared.
    localparam bit   RST_ACTIVE_LOW = 1'b1;
    localparam logic RST_LEVEL      = RST_ACTIVE_LOW ? 1'b0 : 1'b1;

    // Three 1-bit inputs give eight input combinations to cover.
    localparam int unsigned IN_W  = 3;
    localparam int unsigned COV_W = 1 << IN_W;

    typedef logic [IN_W-1:0]  combo_t;
    typedef logic [COV_W-1:0] cov_t;

    // Registered copy of the adder result.
    typedef struct packed {
        logic c;
        logic s;
    } sum_t;

    // One-hot mask selecting the coverage bit of an input combination.
    function automatic cov_t combo_mask(input combo_t idx);
        return cov_t'(1) << idx;
    endfunction

endpackage

// File: rtl/fulladder_half_adder.sv
// half_adder: 1-bit half adder used twice inside fulladder.
// Ports:
//   a, b   in   addends
//   sum    out  a ^ b (combinational)
//   carry  out  a & b (combinational)
`timescale 1ns/1ps
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/fulladder.sv
// fulladder: 1-bit full adder leaf cell with registered result copies and a
// sticky input-combination coverage vector for in-system checking.
// Ports:
//   clk    in   rising-edge clock, used only by s_q/c_q/cov
//   rst_n  in   asynchronous active-low reset
//   x, y   in   addends
//   z      in   carry-in
//   s, c   out  sum / carry-out, combinational, independent of clk/rst_n
//   s_q    out  s registered on clk
//   c_q    out  c registered on clk
//   cov    out  sticky coverage, bit {x,y,z} set once that combination is sampled
`timescale 1ns/1ps
module fulladder
    import fulladder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic [COV_W-1:0] cov
);

    logic p;
    logic g0;
    logic g1;

    sum_t res_q;
    cov_t cov_q;

    // First stage: propagate/generate of the two addends.
    half_adder ha0 (
        .a     (x),
        .b     (y),
        .sum   (p),
        .carry (g0)
    );

    // Second stage folds in the carry-in; its sum is the cell sum.
    half_adder ha1 (
        .a     (p),
        .b     (z),
        .sum   (s),
        .carry (g1)
    );

    // Carry-out: generated by the addends or propagated from carry-in.
    assign c = g0 | g1;

    // Registered result and sticky coverage share one reset domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_LEVEL) begin
            res_q <= '0;
            cov_q <= '0;
        end else begin
            res_q <= '{c: c, s: s};
            cov_q <= cov_q | combo_mask(combo_t'({x, y, z}));
        end
    end

    assign s_q = res_q.s;
    assign c_q = res_q.c;
    assign cov = cov_q;

endmodule

// File: tb/tb_fulladder.sv
`timescale 1ns/1ps
module tb_fulladder;

    logic       clk;
    logic       rst_n;
    logic       x;
    logic       y;
    logic       z;
    logic       s;
    logic       c;
    logic       s_q;
    logic       c_q;
    logic [7:0] cov;

    logic       clk_en;
    int         errors;
    int         checks;
    logic [1:0] exp_q[$];   // expected {c,s} per sampled edge
    logic [7:0] cov_exp;

    fulladder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .z     (z),
        .s     (s),
        .c     (c),
        .s_q   (s_q),
        .c_q   (c_q),
        .cov   (cov)
    );

    // Clock runs only when enabled so the combinational path can be tested idle.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Arithmetic reference: 2-bit sum of three bits.
    function automatic logic [1:0] ref_sum(input logic a, input logic b, input logic d);
        return 2'(a) + 2'(b) + 2'(d);
    endfunction

    task automatic drive(input logic [2:0] v);
        x = v[2];
        y = v[1];
        z = v[0];
    endtask

    task automatic check_comb(input string name);
        logic [1:0] e;
        e = ref_sum(x, y, z);
        checks++;
        if ({c, s} !== e) begin
            errors++;
            $display("FAIL %s: xyz=%b%b%b got {c,s}=%b%b expected %b", name, x, y, z, c, s, e);
        end
    endtask

    // Drive one vector, push its expected registered result, clock it, then pop and compare.
    task automatic step(input logic [2:0] v, input string name);
        logic [1:0] e;
        drive(v);
        #1;
        check_comb(name);
        exp_q.push_back(ref_sum(v[2], v[1], v[0]));
        cov_exp = cov_exp | (8'h01 << v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({c_q, s_q} !== e) begin
            errors++;
            $display("FAIL %s_reg: vec=%b got {c_q,s_q}=%b%b expected %b", name, v, c_q, s_q, e);
        end
        checks++;
        if (cov !== cov_exp) begin
            errors++;
            $display("FAIL %s_cov: vec=%b got cov=%h expected %h", name, v, cov, cov_exp);
        end
    endtask

    task automatic test_comb_idle();
        logic [2:0] v;
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            drive(v);
            #3;
            check_comb("comb_idle");
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        rst_n  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            @(posedge clk);
            #1;
            check_comb("reset_comb");
            checks++;
            if ({c_q, s_q, cov} !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold: got c_q=%b s_q=%b cov=%h expected 0 0 00", c_q, s_q, cov);
            end
        end
    endtask

    task automatic test_first_vector();
        exp_q.delete();
        cov_exp = 8'h00;
        rst_n = 1'b1;
        step(3'b101, "first");
        checks++;
        if ({c_q, s_q, cov} !== {1'b1, 1'b0, 8'h20}) begin
            errors++;
            $display("FAIL first_abs: got c_q=%b s_q=%b cov=%h expected 1 0 20", c_q, s_q, cov);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) step(3'(i), "sweep");
        checks++;
        if (cov !== 8'hFF) begin
            errors++;
            $display("FAIL sweep_full_cov: got cov=%h expected ff", cov);
        end
    endtask

    task automatic test_mid_reset();
        step(3'b111, "pre_reset");
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c_q, s_q, cov} !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset_regs: got c_q=%b s_q=%b cov=%h expected 0 0 00", c_q, s_q, cov);
        end
        checks++;
        if ({c, s} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_comb: got c=%b s=%b expected 1 1", c, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({c_q, s_q, cov} !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset_edge: got c_q=%b s_q=%b cov=%h expected 0 0 00", c_q, s_q, cov);
        end
        exp_q.delete();
        cov_exp = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) step(3'($urandom_range(0, 7)), "random");
    endtask

    initial begin
        clk     = 1'b0;
        clk_en  = 1'b0;
        rst_n   = 1'b0;
        x       = 1'b0;
        y       = 1'b0;
        z       = 1'b0;
        errors  = 0;
        checks  = 0;
        cov_exp = 8'h00;

        test_comb_idle();
        test_reset();
        test_first_vector();
        test_sweep();
        test_mid_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
